// File: rtl/vu_level_meter_pkg.sv
// vu_pkg: shared constants, hold-marker state type and the peak-to-level
// quantiser used by vu_level_meter.
// Optional feature macro: VU_PEAK_HOLD_EN (hold FSM, see vu_level_meter).
package vu_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned BAR_W    = 128;
    localparam int unsigned LVL_W    = $clog2(BAR_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FALL
    } hold_state_e;

    // ceil(peak * bar_w / 2^(sample_w-1)), clamped to bar_w.
    function automatic longint unsigned quantise(
        input longint unsigned peak,
        input int unsigned     sample_w,
        input int unsigned     bar_w
    );
        longint unsigned full_scale;
        longint unsigned t;
        full_scale = 64'd1 << (sample_w - 1);
        t = (peak * 64'(bar_w) + full_scale - 64'd1) >> (sample_w - 1);
        if (t > 64'(bar_w)) begin
            t = 64'(bar_w);
        end
        return t;
    endfunction

endpackage

// File: rtl/vu_thermo_encode.sv
// vu_thermo_encode: combinational thermometer encoder.
// Ports:
//   level_i    - number of lit segments from the bottom (0..BAR_W)
//   mark_pos_i - marker position; 0 = no marker, n lights segment n-1
//   bar_o      - BAR_W-bit segment pattern, bit 0 = bottom
module vu_thermo_encode #(
    parameter int unsigned BAR_W = 128,
    parameter int unsigned LVL_W = 8
) (
    input  logic [LVL_W-1:0] level_i,
    input  logic [LVL_W-1:0] mark_pos_i,
    output logic [BAR_W-1:0] bar_o
);

    always_comb begin
        bar_o = '0;
        for (int unsigned i = 0; i < BAR_W; i++) begin
            bar_o[i] = (i < 32'(level_i)) || (32'(mark_pos_i) == i + 1);
        end
    end

endmodule

// File: rtl/vu_level_meter.sv
// vu_level_meter: PCM peak meter feeding the vga_sync bar display.
// Finds |sample| peak per WINDOW samples, quantises it to BAR_W segments,
// attacks instantly, decays DECAY_STEP segments per frame_tick, and only
// updates bar_out on the cycle after a frame_tick.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   sample_valid  - sample qualifier
//   sample        - signed two's-complement PCM sample
//   frame_tick    - one-cycle pulse at start of vertical blanking
//   bar_out       - thermometer pattern (plus optional hold marker)
//   bar_update    - pulses in the cycle bar_out has just been loaded
//   level_out     - current lit segment count
//   clip          - last completed window reached full scale
// Optional feature macro: VU_PEAK_HOLD_EN enables the peak-hold marker FSM.
module vu_level_meter #(
    parameter int unsigned SAMPLE_W    = 16,
    parameter int unsigned BAR_W       = 128,
    parameter int unsigned WINDOW      = 1024,
    parameter int unsigned DECAY_STEP  = 2,
    parameter int unsigned HOLD_FRAMES = 30
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic                       frame_tick,
    output logic [BAR_W-1:0]           bar_out,
    output logic                       bar_update,
    output logic [7:0]                 level_out,
    output logic                       clip
);

    import vu_pkg::*;

    localparam int unsigned LW  = $clog2(BAR_W + 1);
    localparam int unsigned WCW = $clog2(WINDOW);
    localparam logic [LW-1:0]  DSTEP    = LW'(DECAY_STEP);
    localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);

    // ---------------- magnitude ----------------
    logic [SAMPLE_W-2:0] mag;
    logic [SAMPLE_W-1:0] neg;

    always_comb begin
        neg = -sample;
        mag = sample[SAMPLE_W-2:0];
        if (sample[SAMPLE_W-1]) begin
            // most negative value has no positive twin: saturate
            if (sample[SAMPLE_W-2:0] == '0) begin
                mag = '1;
            end else begin
                mag = neg[SAMPLE_W-2:0];
            end
        end
    end

    // ---------------- window peak ----------------
    logic [WCW-1:0]      win_cnt_q, win_cnt_d;
    logic [SAMPLE_W-2:0] acc_q, acc_d;
    logic [SAMPLE_W-2:0] peak_q, peak_d;
    logic [SAMPLE_W-2:0] win_max;
    logic                win_done_q, win_done_d;
    logic                clip_q, clip_d;

    always_comb begin
        win_max    = (mag > acc_q) ? mag : acc_q;
        win_cnt_d  = win_cnt_q;
        acc_d      = acc_q;
        peak_d     = peak_q;
        clip_d     = clip_q;
        win_done_d = 1'b0;
        if (sample_valid) begin
            if (win_cnt_q == WIN_LAST) begin
                peak_d     = win_max;
                clip_d     = &win_max;
                acc_d      = '0;
                win_cnt_d  = '0;
                win_done_d = 1'b1;
            end else begin
                acc_d     = win_max;
                win_cnt_d = win_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- level: attack then decay ----------------
    logic [LW-1:0] target;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] lvl_atk;
    logic [LW-1:0] diff;

    assign target = LW'(quantise(64'(peak_q), SAMPLE_W, BAR_W));

    always_comb begin
        lvl_atk = (win_done_q && (target > level_q)) ? target : level_q;
        diff    = lvl_atk - target;
        level_d = lvl_atk;
        if (frame_tick && (lvl_atk > target)) begin
            level_d = lvl_atk - ((diff > DSTEP) ? DSTEP : diff);
        end
    end

    // ---------------- optional peak-hold marker ----------------
    logic [LW-1:0] hold_pos_d;

`ifdef VU_PEAK_HOLD_EN
    localparam int unsigned HCW = $clog2(HOLD_FRAMES + 2);

    hold_state_e    hold_st_q, hold_st_d;
    logic [LW-1:0]  hold_pos_q;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

    // Tracks the pre-tick level so a fresh peak is captured at full height.
    always_comb begin
        hold_st_d  = hold_st_q;
        hold_pos_d = hold_pos_q;
        hold_cnt_d = hold_cnt_q;
        if (frame_tick) begin
            if (level_q > hold_pos_q) begin
                hold_pos_d = level_q;
                hold_cnt_d = HCW'(HOLD_FRAMES);
                hold_st_d  = HOLD;
            end else begin
                case (hold_st_q)
                    HOLD: begin
                        if (hold_cnt_q <= HCW'(1)) begin
                            hold_cnt_d = '0;
                            hold_st_d  = FALL;
                        end else begin
                            hold_cnt_d = hold_cnt_q - 1'b1;
                        end
                    end
                    FALL: begin
                        if (hold_pos_q - 1'b1 <= level_q) begin
                            hold_pos_d = level_q;
                            hold_st_d  = IDLE;
                        end else begin
                            hold_pos_d = hold_pos_q - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_st_q  <= IDLE;
            hold_pos_q <= '0;
            hold_cnt_q <= '0;
        end else begin
            hold_st_q  <= hold_st_d;
            hold_pos_q <= hold_pos_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign hold_pos_d = '0;
`endif

    // ---------------- bar register ----------------
    logic [BAR_W-1:0] bar_d;
    logic [BAR_W-1:0] bar_q;
    logic             bar_upd_q;

    vu_thermo_encode #(
        .BAR_W (BAR_W),
        .LVL_W (LW)
    ) u_thermo (
        .level_i    (level_d),
        .mark_pos_i (hold_pos_d),
        .bar_o      (bar_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q  <= '0;
            acc_q      <= '0;
            peak_q     <= '0;
            win_done_q <= 1'b0;
            clip_q     <= 1'b0;
            level_q    <= '0;
            bar_q      <= '0;
            bar_upd_q  <= 1'b0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            acc_q      <= acc_d;
            peak_q     <= peak_d;
            win_done_q <= win_done_d;
            clip_q     <= clip_d;
            level_q    <= level_d;
            bar_upd_q  <= frame_tick;
            if (frame_tick) begin
                bar_q <= bar_d;
            end
        end
    end

    assign bar_out    = bar_q;
    assign bar_update = bar_upd_q;
    assign level_out  = 8'(level_q);
    assign clip       = clip_q;

endmodule

// File: tb/tb_vu_level_meter.sv
module tb_vu_level_meter;

    localparam int SW    = 16;
    localparam int BW    = 128;
    localparam int WIN   = 4;
    localparam int DSTEP = 2;
    localparam int HF    = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sample_valid;
    logic signed [SW-1:0] sample;
    logic                 frame_tick;
    logic [BW-1:0]        bar_out;
    logic                 bar_update;
    logic [7:0]           level_out;
    logic                 clip;

    always #5 clk = ~clk;

    vu_level_meter #(
        .SAMPLE_W    (SW),
        .BAR_W       (BW),
        .WINDOW      (WIN),
        .DECAY_STEP  (DSTEP),
        .HOLD_FRAMES (HF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .frame_tick   (frame_tick),
        .bar_out      (bar_out),
        .bar_update   (bar_update),
        .level_out    (level_out),
        .clip         (clip)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_win[$];
    int            m_peak, m_level;
    bit            m_wd, m_clip, m_upd;
    logic [BW-1:0] m_bar;
    int            m_hpos, m_age;
    bit            m_hact;

    function automatic int mag_of(input int s);
        if (s == -32768) return 32767;
        return (s < 0) ? -s : s;
    endfunction

    function automatic logic [BW-1:0] bar_of(input int lvl, input int mark);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < lvl; i++) b[i] = 1'b1;
        if (mark > 0) b[mark-1] = 1'b1;
        return b;
    endfunction

    task automatic model_edge();
        int tgt, lvl, pk;
        if (rst) begin
            m_win.delete();
            m_peak = 0; m_level = 0; m_wd = 0; m_clip = 0; m_upd = 0;
            m_bar = '0; m_hpos = 0; m_age = 0; m_hact = 0;
            return;
        end
        tgt = (m_peak * BW + 32767) / 32768;
        if (tgt > BW) tgt = BW;
        lvl = m_level;
        if (m_wd && tgt > lvl) lvl = tgt;
        if (frame_tick && lvl > tgt) lvl -= ((lvl - tgt) > DSTEP) ? DSTEP : (lvl - tgt);
`ifdef VU_PEAK_HOLD_EN
        if (frame_tick) begin
            if (m_level > m_hpos) begin
                m_hpos = m_level; m_age = 0; m_hact = 1;
            end else if (m_hact) begin
                m_age++;
                if (m_age > HF) begin
                    m_hpos--;
                    if (m_hpos <= m_level) begin
                        m_hpos = m_level; m_hact = 0;
                    end
                end
            end
        end
`endif
        m_upd = frame_tick;
        if (frame_tick) m_bar = bar_of(lvl, m_hpos);
        m_wd = 0;
        if (sample_valid) begin
            m_win.push_back(mag_of(int'(sample)));
            if (m_win.size() == WIN) begin
                pk = 0;
                foreach (m_win[i]) if (m_win[i] > pk) pk = m_win[i];
                m_peak = pk;
                m_clip = (pk == 32767);
                m_wd   = 1;
                m_win.delete();
            end
        end
        m_level = lvl;
    endtask

    task automatic step(input bit v, input int s, input bit t);
        sample_valid = v;
        sample       = 16'(s);
        frame_tick   = t;
        @(posedge clk);
        model_edge();
        #1;
        check("level", 128'(level_out), 128'(m_level));
        check("bar", bar_out, m_bar);
        check("update", 128'(bar_update), 128'(m_upd));
        check("clip", 128'(clip), 128'(m_clip));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic window4(input int a, input int b, input int c, input int d);
        step(1'b1, a, 1'b0);
        step(1'b1, b, 1'b0);
        step(1'b1, c, 1'b0);
        step(1'b1, d, 1'b0);
    endtask

    initial begin
        rst = 1'b1; sample_valid = 1'b0; sample = '0; frame_tick = 1'b0;

        // reset with random samples flowing
        for (int i = 0; i < 5; i++) begin
            step(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'(i == 2));
            check("rst_bar", bar_out, '0);
            check("rst_level", 128'(level_out), '0);
        end
        rst = 1'b0;
        step(1'b0, 0, 1'b1);
        check("first_upd", 128'(bar_update), 128'(1));
        check("first_bar", bar_out, '0);

        // attack
        do_reset();
        window4(100, -300, 50, 0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        check("atk_level", 128'(level_out), 128'(2));
        step(1'b0, 0, 1'b1);
        check("atk_bar", bar_out, 128'h3);

        // saturation and clip
        do_reset();
        window4(7, -32768, 3, 0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        check("sat_clip", 128'(clip), 128'(1));
        check("sat_level", 128'(level_out), 128'(128));
        step(1'b0, 0, 1'b1);
        check("sat_bar", bar_out, '1);
        window4(0, 0, 0, 0);
        step(1'b0, 0, 1'b0);
        check("clip_clear", 128'(clip), 128'(0));

        // decay from 10 toward silence
        do_reset();
        window4(2560, 0, 0, 0);
        window4(0, 0, 0, 0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        check("dec_start", 128'(level_out), 128'(10));
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 0, 1'b1);
`ifndef VU_PEAK_HOLD_EN
            check("dec_bar", bar_out, bar_of((k < 5) ? 8 - 2 * k : 0, 0));
`endif
            check("dec_level", 128'(level_out), 128'((k < 5) ? 8 - 2 * k : 0));
        end

        // attack and decay in the same cycle
        do_reset();
        window4(5120, 0, 0, 0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        check("sim_pre", 128'(level_out), 128'(20));
        window4(1200, 0, 0, 0);
        step(1'b0, 0, 1'b1);
        check("sim_level", 128'(level_out), 128'(18));

`ifdef VU_PEAK_HOLD_EN
        // peak hold marker
        do_reset();
        window4(10240, 0, 0, 0);
        window4(0, 0, 0, 0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 0, 1'b1);
            check("hold_bar", bar_out, bar_of(40 - 2 * k, (k <= 4) ? 40 : 44 - k));
        end
`endif

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            int sel, s;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       s = -32768;
                1:       s = 32767;
                2:       s = 0;
                3:       s = int'($urandom_range(0, 600)) - 300;
                default: s = int'($urandom_range(0, 65535)) - 32768;
            endcase
            rst = ($urandom_range(0, 199) == 0);
            step(1'($urandom_range(0, 3) != 0), s, 1'($urandom_range(0, 15) == 0));
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
